// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: hazard controls, redirect, instruction memory port,
// Decode-stage outputs, performance counters and debug visibility of PCF/ValidF.
interface fetch_unit_if;
  // Hazard / redirect controls (from hazard unit and Execute)
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  // Synchronous instruction memory: valid/ready-free port; address is taken
  // at every rising edge and the read data is presented for the whole next cycle.
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  // Decode stage
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  // Performance counters
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
  // Debug view of internal fetch state
  logic [31:0] PCFDbg;
  logic        ValidFDbg;

  // Fetch unit side
  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, ImemRdata,
    output ImemAddr, InstrD, PCD, PCPlus4D, ValidD, FetchCount, BubbleCount,
           PCFDbg, ValidFDbg
  );

  // Surrounding pipeline / memory side
  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, ImemRdata,
    input  ImemAddr, InstrD, PCD, PCPlus4D, ValidD, FetchCount, BubbleCount,
           PCFDbg, ValidFDbg
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage plus Fetch/Decode pipeline register for an in-order pipeline
// with a synchronous (one-cycle latency) instruction memory.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.slave  bus
);

  logic [31:0] pcf_q;
  logic        validf_q;
  logic [31:0] instrd_q;
  logic [31:0] pcd_q;
  logic [31:0] pcplus4d_q;
  logic        validd_q;
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  logic [31:0] pcf_plus4;
  logic [31:0] pc_next_d;

  assign pcf_plus4 = pcf_q + 32'd4;

  // Next-PC select. Redirect wins over stall. While ValidF is still 0 the
  // memory output does not yet belong to PCF, so PCF is held as well: the
  // memory reads RESET_VECTOR again and the first capture carries PCD=RESET_VECTOR.
  always_comb begin
    pc_next_d = pcf_plus4;
    if (bus.PCSrcE) begin
      pc_next_d = bus.PCTargetE;
    end else if (bus.StallF || !validf_q) begin
      pc_next_d = pcf_q;
    end
    pc_next_d[1:0] = 2'b00;
  end

  // During reset the memory is pointed at the reset vector regardless of inputs.
  assign bus.ImemAddr = rst ? {RESET_VECTOR[31:2], 2'b00} : pc_next_d;

  // PC and fetch-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q    <= RESET_VECTOR;
      validf_q <= 1'b0;
    end else begin
      pcf_q    <= pc_next_d;
      validf_q <= 1'b1;
    end
  end

  // Decode register and performance counters: hold > bubble > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrd_q     <= NOP_INSTR;
      pcd_q        <= 32'd0;
      pcplus4d_q   <= 32'd0;
      validd_q     <= 1'b0;
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else if (bus.StallD) begin
      instrd_q     <= instrd_q;
      pcd_q        <= pcd_q;
      pcplus4d_q   <= pcplus4d_q;
      validd_q     <= validd_q;
      fetch_cnt_q  <= fetch_cnt_q;
      bubble_cnt_q <= bubble_cnt_q;
    end else if (bus.FlushD || !validf_q) begin
      instrd_q     <= NOP_INSTR;
      pcd_q        <= pcf_q;
      pcplus4d_q   <= pcf_plus4;
      validd_q     <= 1'b0;
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else begin
      instrd_q     <= bus.ImemRdata;
      pcd_q        <= pcf_q;
      pcplus4d_q   <= pcf_plus4;
      validd_q     <= 1'b1;
      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.InstrD      = instrd_q;
  assign bus.PCD         = pcd_q;
  assign bus.PCPlus4D    = pcplus4d_q;
  assign bus.ValidD      = validd_q;
  assign bus.FetchCount  = fetch_cnt_q;
  assign bus.BubbleCount = bubble_cnt_q;
  assign bus.PCFDbg      = pcf_q;
  assign bus.ValidFDbg   = validf_q;

endmodule
